// File: rtl/stream_matrix_transposer_if.sv
// Element stream bundle for stream_matrix_transposer: input and output handshakes,
// per-matrix transpose enable and per-bank occupancy flags.
interface stream_matrix_transposer_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_tr_en;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;
   logic [1:0]            bank_full;

   modport master (
      output in_data, in_valid, in_tr_en, out_ready,
      input  in_ready, out_data, out_valid, out_last, bank_full
   );

   modport slave (
      input  in_data, in_valid, in_tr_en, out_ready,
      output in_ready, out_data, out_valid, out_last, bank_full
   );
endinterface

// File: rtl/stream_matrix_transposer.sv
// Streaming ROWS x COLS matrix transposer with a two-bank ping-pong store.
// A mode bit latched with each matrix's first element selects transposed or pass-through order.
module stream_matrix_transposer #(
   parameter int unsigned ROWS       = 4,
   parameter int unsigned COLS       = 4,
   parameter int unsigned DATA_WIDTH = 8
) (
   input logic                       clk,
   input logic                       rst,
   stream_matrix_transposer_if.slave bus
);
   localparam int unsigned N  = ROWS * COLS;
   localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
   localparam logic [AW-1:0] LastIdx = AW'(N - 1);
   localparam logic [AW-1:0] LastRow = AW'(ROWS - 1);
   localparam logic [AW-1:0] LastCol = AW'(COLS - 1);

   logic [DATA_WIDTH-1:0] mem [2][N];

   logic          wb_q, wb_d, rb_q, rb_d;
   logic [AW-1:0] wi_q, wi_d;
   logic [AW-1:0] oc_q, oc_d, orr_q, orr_d, li_q, li_d;
   logic [1:0]    full_q, full_d;
   logic [1:0]    mode_q, mode_d;

   logic          in_hs, out_hs, last_pos;
   logic [AW-1:0] raddr;

   // All status outputs come from registers only; no valid/ready feed-through.
   assign bus.in_ready  = !full_q[wb_q];
   assign bus.out_valid = full_q[rb_q];
   assign bus.bank_full = full_q;
   assign bus.out_last  = full_q[rb_q] && last_pos;
   assign bus.out_data  = mem[rb_q][raddr];

   assign in_hs  = bus.in_valid && !full_q[wb_q];
   assign out_hs = bus.out_ready && full_q[rb_q];

   always_comb begin
      if (mode_q[rb_q]) begin
         raddr    = AW'(32'(orr_q) * COLS + 32'(oc_q));
         last_pos = (oc_q == LastCol) && (orr_q == LastRow);
      end else begin
         raddr    = li_q;
         last_pos = (li_q == LastIdx);
      end
   end

   always_comb begin
      wb_d   = wb_q;
      wi_d   = wi_q;
      rb_d   = rb_q;
      oc_d   = oc_q;
      orr_d  = orr_q;
      li_d   = li_q;
      full_d = full_q;
      mode_d = mode_q;

      if (in_hs) begin
         if (wi_q == '0) mode_d[wb_q] = bus.in_tr_en;
         if (wi_q == LastIdx) begin
            full_d[wb_q] = 1'b1;
            wi_d         = '0;
            wb_d         = ~wb_q;
         end else begin
            wi_d = wi_q + AW'(1);
         end
      end

      // Writer and reader never share a bank here, so both flag updates can land together.
      if (out_hs) begin
         if (last_pos) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
            oc_d         = '0;
            orr_d        = '0;
            li_d         = '0;
         end else if (mode_q[rb_q]) begin
            if (orr_q == LastRow) begin
               orr_d = '0;
               oc_d  = oc_q + AW'(1);
            end else begin
               orr_d = orr_q + AW'(1);
            end
         end else begin
            li_d = li_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_q   <= 1'b0;
         wi_q   <= '0;
         rb_q   <= 1'b0;
         oc_q   <= '0;
         orr_q  <= '0;
         li_q   <= '0;
         full_q <= 2'b00;
         mode_q <= 2'b00;
      end else begin
         wb_q   <= wb_d;
         wi_q   <= wi_d;
         rb_q   <= rb_d;
         oc_q   <= oc_d;
         orr_q  <= orr_d;
         li_q   <= li_d;
         full_q <= full_d;
         mode_q <= mode_d;
      end
   end

   // Bank contents survive reset; only the occupancy flags are cleared.
   always_ff @(posedge clk) begin
      if (in_hs) mem[wb_q][wi_q] <= bus.in_data;
   end
endmodule

// File: tb/tb_stream_matrix_transposer.sv
// Directed bench for stream_matrix_transposer: 2x3, 4x4 and 1x1 instances side by side.
module tb_stream_matrix_transposer;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   stream_matrix_transposer_if #(.DATA_WIDTH(8)) s_if ();
   stream_matrix_transposer_if #(.DATA_WIDTH(8)) b_if ();
   stream_matrix_transposer_if #(.DATA_WIDTH(8)) o_if ();

   stream_matrix_transposer #(.ROWS(2), .COLS(3), .DATA_WIDTH(8)) u_small (
      .clk (clk),
      .rst (rst),
      .bus (s_if.slave)
   );
   stream_matrix_transposer #(.ROWS(4), .COLS(4), .DATA_WIDTH(8)) u_big (
      .clk (clk),
      .rst (rst),
      .bus (b_if.slave)
   );
   stream_matrix_transposer #(.ROWS(1), .COLS(1), .DATA_WIDTH(8)) u_one (
      .clk (clk),
      .rst (rst),
      .bus (o_if.slave)
   );

   // Inputs change on the falling edge; handshakes are judged from the values seen there.
   task automatic small_run(input logic [7:0] din[$], input logic ten[$], input int nout,
                            output logic [7:0] dout[$], output logic lout[$],
                            output int last_in_cyc, output int first_ov_cyc);
      int i   = 0;
      int cyc = 0;
      dout = {};
      lout = {};
      last_in_cyc  = -1;
      first_ov_cyc = -1;
      while ((i < din.size() || dout.size() < nout) && cyc < 200) begin
         @(negedge clk);
         s_if.out_ready = 1'b1;
         s_if.in_valid  = (i < din.size());
         if (i < din.size()) begin
            s_if.in_data  = din[i];
            s_if.in_tr_en = ten[i];
         end
         if (s_if.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
         if (s_if.out_valid && s_if.out_ready) begin
            dout.push_back(s_if.out_data);
            lout.push_back(s_if.out_last);
         end
         if (s_if.in_valid && s_if.in_ready) begin
            i++;
            last_in_cyc = cyc;
         end
         cyc++;
      end
      @(negedge clk);
      s_if.in_valid  = 1'b0;
      s_if.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (s_if.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b expected 1", s_if.in_ready);
      end
      checks++;
      if (s_if.out_valid !== 1'b0 || s_if.out_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: got valid=%b last=%b expected 0 0", s_if.out_valid,
                  s_if.out_last);
      end
      checks++;
      if (b_if.bank_full !== 2'b00 || s_if.bank_full !== 2'b00) begin
         errors++;
         $display("FAIL reset_bank_full: got %b/%b expected 00", b_if.bank_full, s_if.bank_full);
      end
      checks++;
      if (b_if.in_ready !== 1'b1 || o_if.in_ready !== 1'b1 || o_if.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_other: got big_rdy=%b one_rdy=%b one_vld=%b expected 1 1 0",
                            b_if.in_ready, o_if.in_ready, o_if.out_valid);
      end
      rst = 1'b0;
   endtask

   task automatic test_transpose();
      logic [7:0] din[$], dout[$], exp_d[6];
      logic       ten[$], lout[$];
      int         lin, fov;
      exp_d = '{8'd1, 8'd4, 8'd2, 8'd5, 8'd3, 8'd6};
      for (int k = 0; k < 6; k++) begin
         din.push_back(8'(k + 1));
         ten.push_back(1'b1);
      end
      small_run(din, ten, 6, dout, lout, lin, fov);
      checks++;
      if (dout.size() != 6) begin
         errors++; $display("FAIL transpose_count: got %0d expected 6", dout.size());
      end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (((k < dout.size()) ? dout[k] : 8'hxx) !== exp_d[k]) begin
            errors++; $display("FAIL transpose_data[%0d]: got %0d expected %0d", k,
                               (k < dout.size()) ? dout[k] : 8'hxx, exp_d[k]);
         end
         checks++;
         if (((k < lout.size()) ? lout[k] : 1'bx) !== (k == 5)) begin
            errors++; $display("FAIL transpose_last[%0d]: got %b expected %b", k,
                               (k < lout.size()) ? lout[k] : 1'bx, k == 5);
         end
      end
      checks++;
      if (fov - lin != 1) begin
         errors++; $display("FAIL fill_latency: got %0d expected 1", fov - lin);
      end
   endtask

   task automatic test_bypass();
      logic [7:0] din[$], dout[$];
      logic       ten[$], lout[$];
      int         lin, fov;
      for (int k = 0; k < 6; k++) begin
         din.push_back(8'(k + 1));
         ten.push_back(1'b0);
      end
      small_run(din, ten, 6, dout, lout, lin, fov);
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (((k < dout.size()) ? dout[k] : 8'hxx) !== 8'(k + 1) ||
             ((k < lout.size()) ? lout[k] : 1'bx) !== (k == 5)) begin
            errors++; $display("FAIL bypass[%0d]: got data=%0d last=%b expected %0d %b", k,
                               (k < dout.size()) ? dout[k] : 8'hxx,
                               (k < lout.size()) ? lout[k] : 1'bx, k + 1, k == 5);
         end
      end
   endtask

   task automatic test_mode_per_bank();
      logic [7:0] din[$], dout[$], exp_d[12];
      logic       ten[$], lout[$];
      int         lin, fov;
      exp_d = '{8'd21, 8'd24, 8'd22, 8'd25, 8'd23, 8'd26,
                8'd31, 8'd32, 8'd33, 8'd34, 8'd35, 8'd36};
      for (int k = 0; k < 6; k++) begin
         din.push_back(8'(21 + k));
         ten.push_back(k == 0 || k == 3);
      end
      for (int k = 0; k < 6; k++) begin
         din.push_back(8'(31 + k));
         ten.push_back(k != 0);
      end
      small_run(din, ten, 12, dout, lout, lin, fov);
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (((k < dout.size()) ? dout[k] : 8'hxx) !== exp_d[k]) begin
            errors++; $display("FAIL mode_data[%0d]: got %0d expected %0d", k,
                               (k < dout.size()) ? dout[k] : 8'hxx, exp_d[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      int         acc = 0, got = 0, cyc = 0, j, m;
      logic [7:0] held, exp_v;
      logic       stalled;
      b_if.out_ready = 1'b0;
      b_if.in_tr_en  = 1'b1;
      while (cyc < 40) begin
         @(negedge clk);
         b_if.in_valid = 1'b1;
         b_if.in_data  = 8'(acc);
         if (b_if.in_ready) acc++;
         cyc++;
      end
      checks++;
      if (acc != 32 || b_if.in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_accepted: got %0d ready=%b expected 32 0", acc,
                            b_if.in_ready);
      end
      checks++;
      if (b_if.bank_full !== 2'b11) begin
         errors++; $display("FAIL bp_bank_full: got %b expected 11", b_if.bank_full);
      end
      stalled = b_if.out_valid;
      held    = b_if.out_data;
      cyc     = 0;
      while (got < 48 && cyc < 200) begin
         @(negedge clk);
         if (stalled) begin
            checks++;
            if (b_if.out_data !== held) begin
               errors++; $display("FAIL bp_stable: got %0d expected %0d", b_if.out_data, held);
            end
         end
         b_if.in_valid  = (acc < 48);
         b_if.in_data   = 8'(acc);
         b_if.out_ready = (cyc % 3 != 2);
         if (b_if.in_valid && b_if.in_ready) acc++;
         if (b_if.out_valid && b_if.out_ready) begin
            m     = got / 16;
            j     = got % 16;
            exp_v = 8'(m * 16 + (j % 4) * 4 + j / 4);
            checks++;
            if (b_if.out_data !== exp_v) begin
               errors++; $display("FAIL bp_data[%0d]: got %0d expected %0d", got,
                                  b_if.out_data, exp_v);
            end
            got++;
         end
         stalled = b_if.out_valid && !b_if.out_ready;
         held    = b_if.out_data;
         cyc++;
      end
      @(negedge clk);
      b_if.in_valid  = 1'b0;
      b_if.out_ready = 1'b0;
      checks++;
      if (got != 48 || b_if.bank_full !== 2'b00) begin
         errors++; $display("FAIL bp_drain: got %0d outputs full=%b expected 48 00", got,
                            b_if.bank_full);
      end
   endtask

   task automatic test_back_to_back();
      int         acc = 0, got = 0, cyc = 0, first = -1, lastc = -1, gaps = 0, j, m;
      logic [7:0] exp_v;
      while (got < 80 && cyc < 150) begin
         @(negedge clk);
         cyc++;  // cycle 1 carries the first input handshake
         b_if.in_valid  = (acc < 80);
         b_if.in_data   = 8'(acc);
         b_if.in_tr_en  = ((acc / 16) % 2 == 0);
         b_if.out_ready = 1'b1;
         if (b_if.in_valid && b_if.in_ready) acc++;
         if (b_if.out_valid && b_if.out_ready) begin
            if (first < 0) first = cyc;
            else if (cyc != lastc + 1) gaps++;
            lastc = cyc;
            m     = got / 16;
            j     = got % 16;
            exp_v = (m % 2 == 0) ? 8'(m * 16 + (j % 4) * 4 + j / 4) : 8'(m * 16 + j);
            checks++;
            if (b_if.out_data !== exp_v || b_if.out_last !== (j == 15)) begin
               errors++; $display("FAIL stream_out[%0d]: got %0d last=%b expected %0d %b", got,
                                  b_if.out_data, b_if.out_last, exp_v, j == 15);
            end
            got++;
         end
      end
      @(negedge clk);
      b_if.in_valid  = 1'b0;
      b_if.out_ready = 1'b0;
      checks++;
      if (first != 17) begin
         errors++; $display("FAIL stream_first: got %0d expected 17", first);
      end
      checks++;
      if (got != 80 || gaps != 0 || lastc != 96) begin
         errors++; $display("FAIL stream_rate: got n=%0d gaps=%0d end=%0d expected 80 0 96",
                            got, gaps, lastc);
      end
   endtask

   task automatic test_single();
      int i = 0, got = 0, cyc = 0, stalls = 0;
      while ((i < 3 || got < 3) && cyc < 20) begin
         @(negedge clk);
         cyc++;
         o_if.in_valid  = (i < 3);
         o_if.in_data   = 8'(7 + i);
         o_if.in_tr_en  = i[0];
         o_if.out_ready = 1'b1;
         if (o_if.out_valid) begin
            checks++;
            if (o_if.out_last !== 1'b1) begin
               errors++; $display("FAIL single_last: got %b expected 1", o_if.out_last);
            end
         end
         if (o_if.in_valid && !o_if.in_ready) stalls++;
         if (o_if.in_valid && o_if.in_ready) i++;
         if (o_if.out_valid && o_if.out_ready) begin
            checks++;
            if (o_if.out_data !== 8'(7 + got)) begin
               errors++; $display("FAIL single_data[%0d]: got %0d expected %0d", got,
                                  o_if.out_data, 7 + got);
            end
            got++;
         end
      end
      @(negedge clk);
      o_if.in_valid  = 1'b0;
      o_if.out_ready = 1'b0;
      checks++;
      if (got != 3 || stalls != 0) begin
         errors++; $display("FAIL single_flow: got n=%0d stalls=%0d expected 3 0", got, stalls);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] din[$], dout[$], exp_d[6];
      logic       ten[$], lout[$];
      int         lin, fov;
      exp_d = '{8'd10, 8'd13, 8'd11, 8'd14, 8'd12, 8'd15};
      for (int pass = 0; pass < 2; pass++) begin
         din = {};
         ten = {};
         for (int k = 0; k < ((pass == 0) ? 3 : 6); k++) begin
            din.push_back(8'(41 + k));
            ten.push_back(1'b1);
         end
         small_run(din, ten, (pass == 0) ? 0 : 2, dout, lout, lin, fov);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         checks++;
         if (s_if.out_valid !== 1'b0 || s_if.in_ready !== 1'b1 || s_if.bank_full !== 2'b00) begin
            errors++; $display("FAIL mid_reset[%0d]: got vld=%b rdy=%b full=%b expected 0 1 00",
                               pass, s_if.out_valid, s_if.in_ready, s_if.bank_full);
         end
      end
      din = {};
      ten = {};
      for (int k = 0; k < 6; k++) begin
         din.push_back(8'(10 + k));
         ten.push_back(1'b1);
      end
      small_run(din, ten, 6, dout, lout, lin, fov);
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (((k < dout.size()) ? dout[k] : 8'hxx) !== exp_d[k]) begin
            errors++; $display("FAIL post_reset_data[%0d]: got %0d expected %0d", k,
                               (k < dout.size()) ? dout[k] : 8'hxx, exp_d[k]);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      s_if.in_valid = 1'b0; s_if.in_data = '0; s_if.in_tr_en = 1'b0; s_if.out_ready = 1'b0;
      b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_tr_en = 1'b0; b_if.out_ready = 1'b0;
      o_if.in_valid = 1'b0; o_if.in_data = '0; o_if.in_tr_en = 1'b0; o_if.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      test_transpose();
      test_bypass();
      test_mode_per_bank();
      test_backpressure();
      test_back_to_back();
      test_single();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
